store_load_ctrl: RTL and testbench
==================================

# store_load_ctrl

Upstream control stage for the 4-bit store register built from `FF_Dcom` cells. It debounces the raw store push-button, snapshots the 4 data switches, and emits a clean single-cycle `st` pulse with stable `D`. One accepted pulse is produced per physical press. It also counts accepted stores for display and debug.

## Interface
Parameters:
- `DB_CYCLES`, default 1000000: consecutive stable samples required to accept a press or release. Legal range is ≥ 2. Benches use 4.
- `CW`, default `$clog2(DB_CYCLES)`: debounce counter width.

Ports:
- `clk` input, 1 bit: system clock. Everything is on the rising edge.
- `clr` input, 1 bit: synchronous, active-high reset.
- `btn_st` input, 1 bit: raw, asynchronous, bouncing store button. Active high.
- `sw` input, 4 bits: raw data switches. Quasi-static.
- `D` output, 4 bits: registered snapshot of `sw`. Feeds the store register data input.
- `st` output, 1 bit: one-cycle store strobe. Feeds the store register `St` input.
- `busy` output, 1 bit: high whenever the FSM is not in IDLE.
- `load_cnt` output, 8 bits: number of accepted stores. Wraps modulo 256.

## Operation
- **Synchronizer:** `btn_st` passes through 2 flops (`s1`, `s2`); `btn_s = s2`. Both flops clear to 0 on `clr`.
- **FSM states:** IDLE, PRESS_CNT, FIRE, HELD, REL_CNT. The counter `cnt` is CW bits wide.
- **IDLE:**
  - `btn_s=1` → PRESS_CNT, `cnt<=1`.
  - Otherwise stay, `cnt<=0`.
- **PRESS_CNT:**
  - `btn_s=0` → IDLE, `cnt<=0`. Bounce rejected; no pulse.
  - Else if `cnt==DB_CYCLES-1` → FIRE, `D<=sw`, `cnt<=0`.
  - Else `cnt<=cnt+1`.
- **FIRE:** `st=1` for this state only. `load_cnt<=load_cnt+1` (255→0). Unconditionally → HELD.
- **HELD:** `btn_s=0` → REL_CNT, `cnt<=1`. Otherwise stay.
- **REL_CNT:**
  - `btn_s=1` → HELD, `cnt<=0`. Release bounce does not re-trigger.
  - Else if `cnt==DB_CYCLES-1` → IDLE.
  - Else `cnt<=cnt+1`.
- **Outputs:**
  - `st` and `busy` are decoded from registered state only; no input-to-output combinational path.
  - `D` changes only on the FIRE entry edge and holds between presses.
- **Switch timing:** `sw` is sampled once, on the FIRE entry edge. Changes to `sw` at any other time do not affect `D`.
- **Holding the button:** produces exactly one pulse, regardless of hold length.

## Timing
- **Reset values:**
  - `D=0`, `st=0`, `busy=0`, `load_cnt=0`.
  - State IDLE, `cnt=0`, `s1=s2=0`.
- **Press latency:** take edge 0 as the first edge sampling `btn_st=1`.
  - `btn_s=1` after edge 1.
  - PRESS_CNT is entered at edge 2.
  - FIRE is entered at edge `DB_CYCLES+1`, so `st` is high from edge `DB_CYCLES+1` to edge `DB_CYCLES+2`.
  - `D` becomes valid on the same edge that `st` rises. It is stable for the whole `st` cycle and afterwards.
- **Minimum press:** a press is accepted only if `btn_s` stays high for `DB_CYCLES` consecutive samples. A glitch of `DB_CYCLES-1` samples or fewer yields no pulse.
- **Minimum press-to-press spacing:** 1 (FIRE) + ≥1 (HELD) + `DB_CYCLES` (REL_CNT) cycles after `st`.
- **Reset mid-operation:** `clr` wins over every transition in any state.
  - State returns to IDLE.
  - Any pending pulse is cancelled, and `D` and `load_cnt` are zeroed.
  - If the button is still held after reset deasserts, it is treated as a new press: re-synchronized, re-debounced, and fired.
- **`clr` during FIRE:** `st` drops on that edge and `load_cnt` is 0, not incremented.

## Test plan
All scenarios use `DB_CYCLES=4`.
1. **Reset:** hold `clr` for 3 cycles with `btn_st=1` and `sw=4'hF` → `D=0`, `st=0`, `busy=0`, `load_cnt=0`. After release, a pulse still occurs at edge 5, with `D=4'hF` and `load_cnt=1`.
2. **Clean press:** `sw=4'hA`, `btn_st` high for 20 cycles → exactly one `st` pulse, high between edges 5 and 6. `D=4'hA`, `load_cnt=1`, and `busy` is low 4 cycles after `btn_s` falls.
3. **Bounce:** `btn_st` toggles 1,1,0,1,1,1,0 then holds high → no `st` until 4 consecutive high samples of `btn_s`, then exactly one pulse.
4. **Switch change:** change `sw` from 3 to C while in HELD → `D` stays 3. On the next press, `D=4'hC` and `load_cnt=2`.
5. **Release bounce:** during REL_CNT, a 1-cycle high glitch on `btn_st` → return to HELD with no extra `st`. After a clean release, `busy` falls.
6. **Wrap and mid-reset:**
   - 256 presses → `load_cnt` returns to 0.
   - `clr` asserted exactly during FIRE → `st` deasserted at that edge and `load_cnt=0`.

Source files
------------

// File: rtl/store_load_ctrl.sv
// Store-button front end: synchronizes and debounces btn_st, snapshots the data
// switches and emits one clean st strobe per physical press, counting accepted stores.
module store_load_ctrl #(
  parameter int unsigned DB_CYCLES = 1000000,
  parameter int unsigned CW        = $clog2(DB_CYCLES)
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       btn_st,
  input  logic [3:0] sw,
  output logic [3:0] D,
  output logic       st,
  output logic       busy,
  output logic [7:0] load_cnt
);

  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [2:0] {
    IDLE,
    PRESS_CNT,
    FIRE,
    HELD,
    REL_CNT
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          s1;
  logic          s2;
  logic          btn_s;
  logic          load_d;

  assign btn_s = s2;

  // State and debounce counter register
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Debounce FSM: the same counter times both the press and the release windows
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    load_d    = 1'b0;
    case (state)
      IDLE: begin
        if (btn_s) begin
          state_nxt = PRESS_CNT;
          cnt_nxt   = CNT_ONE;
        end else begin
          cnt_nxt = '0;
        end
      end
      PRESS_CNT: begin
        if (!btn_s) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = FIRE;
          cnt_nxt   = '0;
          load_d    = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      FIRE: begin
        state_nxt = HELD;
      end
      HELD: begin
        if (!btn_s) begin
          state_nxt = REL_CNT;
          cnt_nxt   = CNT_ONE;
        end
      end
      REL_CNT: begin
        if (btn_s) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Synchronizer, data snapshot and outputs; st/busy track the state register exactly
  always_ff @(posedge clk) begin
    if (clr) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      D        <= 4'h0;
      st       <= 1'b0;
      busy     <= 1'b0;
      load_cnt <= 8'h00;
    end else begin
      s1   <= btn_st;
      s2   <= s1;
      st   <= (state_nxt == FIRE);
      busy <= (state_nxt != IDLE);
      if (load_d) begin
        D <= sw;
      end
      if (state == FIRE) begin
        load_cnt <= load_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_store_load_ctrl.sv
// Self-checking bench for store_load_ctrl with DB_CYCLES=4: expected D values are
// queued as presses are driven and matched against logged st pulses.
module tb_store_load_ctrl;

  localparam int unsigned DB = 4;

  logic       clk = 1'b0;
  logic       clr;
  logic       btn_st;
  logic [3:0] sw;
  logic [3:0] D;
  logic       st;
  logic       busy;
  logic [7:0] load_cnt;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  logic [3:0] exp_q[$];
  logic [3:0] obs_d  [0:1023];
  int         obs_cyc[0:1023];
  int         obs_wr = 0;
  int         obs_rd = 0;

  store_load_ctrl #(.DB_CYCLES(DB)) dut (
    .clk(clk), .clr(clr), .btn_st(btn_st), .sw(sw),
    .D(D), .st(st), .busy(busy), .load_cnt(load_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Log every cycle in which st is high, with its D and cycle stamp
  always @(negedge clk) begin
    if (st) begin
      obs_d[obs_wr]   <= D;
      obs_cyc[obs_wr] <= cyc;
      obs_wr          <= obs_wr + 1;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_clr();
    clr = 1'b1; btn_st = 1'b0;
    cycles(2);
    clr = 1'b0;
  endtask

  task automatic test_reset();
    int n0, t0; logic [3:0] e;
    clr = 1'b1; btn_st = 1'b1; sw = 4'hF;
    cycles(3);
    vectors++;
    if ({D, st, busy, load_cnt} !== 14'h0) begin
      miscompares++;
      $display("FAIL reset_state: D=%h st=%b busy=%b load_cnt=%0d, want all zero", D, st, busy, load_cnt);
    end
    n0 = obs_wr; t0 = cyc; exp_q.push_back(4'hF);
    clr = 1'b0;
    cycles(8);
    vectors++;
    if (obs_wr - n0 != 1 || obs_cyc[n0] != t0 + 6) begin
      miscompares++;
      $display("FAIL reset_pulse_time: %0d pulses, first at cyc %0d, want 1 at %0d", obs_wr - n0, obs_cyc[n0], t0 + 6);
    end
    vectors++;
    if (load_cnt !== 8'd1) begin
      miscompares++; $display("FAIL reset_load_cnt: got %0d want 1", load_cnt);
    end
    btn_st = 1'b0;
    cycles(8);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++; $display("FAIL reset_busy_idle: got %b want 0", busy);
    end
    while (obs_rd < obs_wr) begin
      vectors++;
      if (exp_q.size() == 0) begin miscompares++; $display("FAIL reset_extra_st: D=%h", obs_d[obs_rd]); end
      else begin e = exp_q.pop_front(); if (obs_d[obs_rd] !== e) begin miscompares++; $display("FAIL reset_pulse_D: got %h want %h", obs_d[obs_rd], e); end end
      obs_rd++;
    end
    vectors++;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL reset_missing_st: %0d pulses absent", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_clean_press();
    int n0, t0; logic [3:0] e;
    do_clr();
    sw = 4'hA; n0 = obs_wr; t0 = cyc; exp_q.push_back(4'hA);
    btn_st = 1'b1;
    cycles(20);
    vectors++;
    if (obs_wr - n0 != 1 || obs_cyc[n0] != t0 + 6) begin
      miscompares++;
      $display("FAIL clean_pulse_time: %0d pulses, first at cyc %0d, want 1 at %0d", obs_wr - n0, obs_cyc[n0], t0 + 6);
    end
    vectors++;
    if (load_cnt !== 8'd1 || D !== 4'hA) begin
      miscompares++; $display("FAIL clean_regs: load_cnt=%0d D=%h want 1 and a", load_cnt, D);
    end
    btn_st = 1'b0;
    cycles(5);
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL clean_busy_rel: got %b want 1", busy); end
    cycles(1);
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL clean_busy_idle: got %b want 0", busy); end
    while (obs_rd < obs_wr) begin
      vectors++;
      if (exp_q.size() == 0) begin miscompares++; $display("FAIL clean_extra_st: D=%h", obs_d[obs_rd]); end
      else begin e = exp_q.pop_front(); if (obs_d[obs_rd] !== e) begin miscompares++; $display("FAIL clean_pulse_D: got %h want %h", obs_d[obs_rd], e); end end
      obs_rd++;
    end
    vectors++;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL clean_missing_st: %0d pulses absent", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_bounce();
    int n0, t0; logic [3:0] e;
    logic seq [0:6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    do_clr();
    sw = 4'h5; n0 = obs_wr; t0 = cyc; exp_q.push_back(4'h5);
    for (int i = 0; i < 7; i++) begin
      btn_st = seq[i];
      cycles(1);
    end
    btn_st = 1'b1;
    cycles(12);
    vectors++;
    if (obs_wr - n0 != 1 || obs_cyc[n0] != t0 + 13) begin
      miscompares++;
      $display("FAIL bounce_pulse_time: %0d pulses, first at cyc %0d, want 1 at %0d", obs_wr - n0, obs_cyc[n0], t0 + 13);
    end
    btn_st = 1'b0;
    cycles(8);
    vectors++;
    if (load_cnt !== 8'd1) begin miscompares++; $display("FAIL bounce_load_cnt: got %0d want 1", load_cnt); end
    while (obs_rd < obs_wr) begin
      vectors++;
      if (exp_q.size() == 0) begin miscompares++; $display("FAIL bounce_extra_st: D=%h", obs_d[obs_rd]); end
      else begin e = exp_q.pop_front(); if (obs_d[obs_rd] !== e) begin miscompares++; $display("FAIL bounce_pulse_D: got %h want %h", obs_d[obs_rd], e); end end
      obs_rd++;
    end
    vectors++;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL bounce_missing_st: %0d pulses absent", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_switch_change();
    int n0; logic [3:0] e;
    do_clr();
    sw = 4'h3; n0 = obs_wr; exp_q.push_back(4'h3);
    btn_st = 1'b1;
    cycles(10);
    sw = 4'hC;
    cycles(5);
    vectors++;
    if (D !== 4'h3) begin miscompares++; $display("FAIL sw_held_D: got %h want 3", D); end
    btn_st = 1'b0;
    cycles(8);
    vectors++;
    if (D !== 4'h3) begin miscompares++; $display("FAIL sw_idle_D: got %h want 3", D); end
    exp_q.push_back(4'hC);
    btn_st = 1'b1;
    cycles(10);
    btn_st = 1'b0;
    cycles(8);
    vectors++;
    if (obs_wr - n0 != 2 || D !== 4'hC || load_cnt !== 8'd2) begin
      miscompares++;
      $display("FAIL sw_second: pulses=%0d D=%h load_cnt=%0d want 2, c, 2", obs_wr - n0, D, load_cnt);
    end
    while (obs_rd < obs_wr) begin
      vectors++;
      if (exp_q.size() == 0) begin miscompares++; $display("FAIL sw_extra_st: D=%h", obs_d[obs_rd]); end
      else begin e = exp_q.pop_front(); if (obs_d[obs_rd] !== e) begin miscompares++; $display("FAIL sw_pulse_D: got %h want %h", obs_d[obs_rd], e); end end
      obs_rd++;
    end
    vectors++;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL sw_missing_st: %0d pulses absent", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_release_bounce();
    int n0; logic [3:0] e;
    do_clr();
    sw = 4'h6; n0 = obs_wr; exp_q.push_back(4'h6);
    btn_st = 1'b1;
    cycles(10);
    btn_st = 1'b0;
    cycles(2);
    btn_st = 1'b1;
    cycles(1);
    btn_st = 1'b0;
    cycles(5);
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL relb_busy_rearmed: got %b want 1", busy); end
    cycles(2);
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL relb_busy_idle: got %b want 0", busy); end
    vectors++;
    if (obs_wr - n0 != 1 || load_cnt !== 8'd1) begin
      miscompares++; $display("FAIL relb_single: pulses=%0d load_cnt=%0d want 1, 1", obs_wr - n0, load_cnt);
    end
    while (obs_rd < obs_wr) begin
      vectors++;
      if (exp_q.size() == 0) begin miscompares++; $display("FAIL relb_extra_st: D=%h", obs_d[obs_rd]); end
      else begin e = exp_q.pop_front(); if (obs_d[obs_rd] !== e) begin miscompares++; $display("FAIL relb_pulse_D: got %h want %h", obs_d[obs_rd], e); end end
      obs_rd++;
    end
    vectors++;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL relb_missing_st: %0d pulses absent", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_wrap_mid_reset();
    int n0, t0; logic [3:0] e;
    do_clr();
    n0 = obs_wr;
    for (int i = 0; i < 256; i++) begin
      sw = 4'(i); exp_q.push_back(4'(i));
      btn_st = 1'b1;
      cycles(6);
      btn_st = 1'b0;
      cycles(8);
    end
    vectors++;
    if (obs_wr - n0 != 256 || load_cnt !== 8'd0) begin
      miscompares++; $display("FAIL wrap_count: pulses=%0d load_cnt=%0d want 256, 0", obs_wr - n0, load_cnt);
    end
    sw = 4'h9; exp_q.push_back(4'h9);
    btn_st = 1'b1;
    for (int k = 0; k < 20 && st !== 1'b1; k++) cycles(1);
    vectors++;
    if (st !== 1'b1) begin miscompares++; $display("FAIL midclr_wait_st: st=%b after 20 cycles, want 1", st); end
    clr = 1'b1;
    cycles(1);
    vectors++;
    if ({D, st, busy, load_cnt} !== 14'h0) begin
      miscompares++;
      $display("FAIL midclr_state: D=%h st=%b busy=%b load_cnt=%0d, want all zero", D, st, busy, load_cnt);
    end
    exp_q.push_back(4'h9);
    t0 = cyc; n0 = obs_wr;
    clr = 1'b0;
    cycles(10);
    vectors++;
    if (obs_wr - n0 != 1 || obs_cyc[n0] != t0 + 6 || load_cnt !== 8'd1) begin
      miscompares++;
      $display("FAIL midclr_repress: pulses=%0d at cyc %0d load_cnt=%0d want 1 at %0d, 1", obs_wr - n0, obs_cyc[n0], load_cnt, t0 + 6);
    end
    btn_st = 1'b0;
    cycles(8);
    while (obs_rd < obs_wr) begin
      vectors++;
      if (exp_q.size() == 0) begin miscompares++; $display("FAIL wrap_extra_st: D=%h", obs_d[obs_rd]); end
      else begin e = exp_q.pop_front(); if (obs_d[obs_rd] !== e) begin miscompares++; $display("FAIL wrap_pulse_D: got %h want %h", obs_d[obs_rd], e); end end
      obs_rd++;
    end
    vectors++;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL wrap_missing_st: %0d pulses absent", exp_q.size()); exp_q.delete(); end
  endtask

  initial begin
    clr = 1'b1; btn_st = 1'b0; sw = 4'h0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_switch_change();
    test_release_bounce();
    test_wrap_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit at cyc %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
